taillight_sequencer: RTL

Sequencing controller for the tail-light panel. It arbitrates between the hazard, turn-signal and brake requests and steps the three-lamp-per-side sweep on a divided-down tick. It drives the LED bank and a one-digit mode indicator. It sits between the board switch/key inputs and the `LEDR`/`HEX0` outputs of the top level.

---
 rtl/taillight_pkg.sv | 41 ++++
 rtl/taillight_sequencer_tick_divider.sv | 27 ++
 rtl/taillight_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/taillight_pkg.sv
// Shared types and constants for the tail-light sequencer: FSM states,
// mode-digit segment codes and LED bank bit positions.
package taillight_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_L1,
    ST_L2,
    ST_L3,
    ST_R1,
    ST_R2,
    ST_R3,
    ST_HAZ_ON,
    ST_HAZ_OFF
  } state_e;

  // Active-low seven-segment codes, {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] HEX_IDLE = 8'hC0;
  localparam logic [7:0] HEX_L    = 8'hC7;
  localparam logic [7:0] HEX_R    = 8'hAF;
  localparam logic [7:0] HEX_HAZ  = 8'h89;
  localparam logic [7:0] HEX_BRK  = 8'h83;

  localparam int LAMP_L1 = 7;
  localparam int LAMP_L2 = 8;
  localparam int LAMP_L3 = 9;
  localparam int LAMP_R1 = 2;
  localparam int LAMP_R2 = 1;
  localparam int LAMP_R3 = 0;

  // Lamp set for sweep step 1..3, ordered {lamp3, lamp2, lamp1}
  function automatic logic [2:0] sweep_lamps(input logic [1:0] step);
    case (step)
      2'd1:    sweep_lamps = 3'b001;
      2'd2:    sweep_lamps = 3'b011;
      2'd3:    sweep_lamps = 3'b111;
      default: sweep_lamps = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/taillight_sequencer_tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, first tick
// TICK_DIV cycles after reset release.
module tick_divider #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic ADC_CLK_10,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/taillight_sequencer.sv
// Tail-light controller: synchronizes requests, steps hazard/turn FSM on the
// divided tick, and decodes lamps and mode digit (brake is Moore on brake_s).
module taillight_sequencer
  import taillight_pkg::*;
#(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic       ADC_CLK_10,
  input  logic       rst,
  input  logic       hazard_req,
  input  logic       turn_req,
  input  logic       turn_dir,
  input  logic       brake_req,
  output logic [9:0] LEDR,
  output logic [7:0] HEX0
);

  logic [3:0] sync1_q, sync2_q;
  logic       hazard_s, turn_s, dir_s, brake_s;
  logic       tick;
  state_e     state_q, state_d;

  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {hazard_req, turn_req, turn_dir, brake_req};
      sync2_q <= sync1_q;
    end
  end

  assign {hazard_s, turn_s, dir_s, brake_s} = sync2_q;

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .ADC_CLK_10 (ADC_CLK_10),
    .rst        (rst),
    .tick       (tick)
  );

  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      if (hazard_s) begin
        state_d = (state_q == ST_HAZ_ON) ? ST_HAZ_OFF : ST_HAZ_ON;
      end else if (turn_s && dir_s) begin
        case (state_q)
          ST_IDLE: state_d = ST_L1;
          ST_L1:   state_d = ST_L2;
          ST_L2:   state_d = ST_L3;
          default: state_d = ST_IDLE;
        endcase
      end else if (turn_s) begin
        case (state_q)
          ST_IDLE: state_d = ST_R1;
          ST_R1:   state_d = ST_R2;
          ST_R2:   state_d = ST_R3;
          default: state_d = ST_IDLE;
        endcase
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  logic [2:0] left_lamps, right_lamps;
  logic       in_left, in_right, in_haz;

  always_comb begin
    in_left     = (state_q == ST_L1) || (state_q == ST_L2) || (state_q == ST_L3);
    in_right    = (state_q == ST_R1) || (state_q == ST_R2) || (state_q == ST_R3);
    in_haz      = (state_q == ST_HAZ_ON) || (state_q == ST_HAZ_OFF);
    left_lamps  = 3'b000;
    right_lamps = 3'b000;
    HEX0        = HEX_IDLE;

    case (state_q)
      ST_L1:     left_lamps  = sweep_lamps(2'd1);
      ST_L2:     left_lamps  = sweep_lamps(2'd2);
      ST_L3:     left_lamps  = sweep_lamps(2'd3);
      ST_R1:     right_lamps = sweep_lamps(2'd1);
      ST_R2:     right_lamps = sweep_lamps(2'd2);
      ST_R3:     right_lamps = sweep_lamps(2'd3);
      ST_HAZ_ON: begin
        left_lamps  = 3'b111;
        right_lamps = 3'b111;
      end
      default: ;
    endcase

    // Brake lights whichever side is not carrying a sweep; hazard masks it
    if (brake_s && !in_haz) begin
      if (in_left)                right_lamps = 3'b111;
      else if (in_right)          left_lamps  = 3'b111;
      else if (turn_s && dir_s)   right_lamps = 3'b111;
      else if (turn_s)            left_lamps  = 3'b111;
      else begin
        left_lamps  = 3'b111;
        right_lamps = 3'b111;
      end
    end

    if (in_haz)                    HEX0 = HEX_HAZ;
    else if (in_left)              HEX0 = HEX_L;
    else if (in_right)             HEX0 = HEX_R;
    else if (turn_s)               HEX0 = dir_s ? HEX_L : HEX_R;
    else if (brake_s)              HEX0 = HEX_BRK;

    LEDR          = '0;
    LEDR[LAMP_L1] = left_lamps[0];
    LEDR[LAMP_L2] = left_lamps[1];
    LEDR[LAMP_L3] = left_lamps[2];
    LEDR[LAMP_R1] = right_lamps[0];
    LEDR[LAMP_R2] = right_lamps[1];
    LEDR[LAMP_R3] = right_lamps[2];
  end

endmodule
